// File: rtl/fetch_pkg.sv
// Shared types and default widths for the instruction fetch sequencer.
// The entry struct is sized from the default widths used by fetch_sequencer.
package fetch_pkg;

  localparam int                ADDR_W_DEF     = 6;
  localparam int                INSTR_W_DEF    = 32;
  localparam int                DEPTH_DEF      = 33;
  localparam logic [INSTR_W_DEF-1:0] HALT_INSTR_DEF = 32'hFFFF_FFFF;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DRAIN,
    HALT
  } fetch_state_t;

  typedef struct packed {
    logic [INSTR_W_DEF-1:0] instr;
    logic [ADDR_W_DEF-1:0]  pc;
  } fetch_entry_t;

endpackage

// File: rtl/fetch_skid_buf.sv
// Two-entry FIFO of fetch entries between the memory capture point and decode.
// Flush wins over push and pop; push is accepted when full only with a pop.
module fetch_skid_buf
  import fetch_pkg::*;
(
  input  logic         clk,
  input  logic         rst,
  input  logic         push_i,
  input  fetch_entry_t push_data_i,
  input  logic         pop_i,
  input  logic         flush_i,
  output logic [1:0]   count_o,
  output fetch_entry_t head_o
);

  fetch_entry_t mem_q [2];
  logic         rd_ptr_q;
  logic         wr_ptr_q;
  logic [1:0]   count_q;
  logic         do_push;
  logic         do_pop;

  assign do_pop  = pop_i && (count_q != 2'd0);
  assign do_push = push_i && ((count_q != 2'd2) || do_pop);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      // NOTE: both storage words are reset because the head drives out_instr/out_pc
      // directly, and those must read 0 straight out of reset.
      mem_q[0] <= '0;
      mem_q[1] <= '0;
      rd_ptr_q <= 1'b0;
      wr_ptr_q <= 1'b0;
      count_q  <= 2'd0;
    end else if (flush_i) begin
      rd_ptr_q <= 1'b0;
      wr_ptr_q <= 1'b0;
      count_q  <= 2'd0;
    end else begin
      if (do_push) begin
        mem_q[wr_ptr_q] <= push_data_i;
        wr_ptr_q        <= ~wr_ptr_q;
      end
      if (do_pop) begin
        rd_ptr_q <= ~rd_ptr_q;
      end
      count_q <= count_q + {1'b0, do_push} - {1'b0, do_pop};
    end
  end

  assign count_o = count_q;
  assign head_o  = mem_q[rd_ptr_q];

endmodule

// File: rtl/fetch_sequencer.sv
// Sequences a 1-cycle-latency instruction memory and feeds decode through a 2-entry buffer.
// Optional FETCH_PERF_EN adds pop and stall counters (perf_fetched, perf_stall).
module fetch_sequencer
  import fetch_pkg::*;
#(
  parameter int                  ADDR_W     = ADDR_W_DEF,
  parameter int                  INSTR_W    = INSTR_W_DEF,
  parameter int                  DEPTH      = DEPTH_DEF,
  parameter logic [INSTR_W-1:0]  HALT_INSTR = HALT_INSTR_DEF
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic [ADDR_W-1:0]  start_pc,
  output logic [ADDR_W-1:0]  mem_addr,
  input  logic [INSTR_W-1:0] mem_rdata,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [INSTR_W-1:0] out_instr,
  output logic [ADDR_W-1:0]  out_pc,
  input  logic               redirect_valid,
  input  logic [ADDR_W-1:0]  redirect_pc,
  output logic               halted
`ifdef FETCH_PERF_EN
  ,
  output logic [31:0]        perf_fetched,
  output logic [31:0]        perf_stall
`endif
);

  fetch_state_t       state_q;
  logic [ADDR_W-1:0]  fetch_pc_q;
  logic [ADDR_W-1:0]  tag_q;
  logic               inflight_q;
  logic [ADDR_W-1:0]  next_pc_d;
  logic [1:0]         count;
  fetch_entry_t       push_entry;
  fetch_entry_t       head;
  logic               pop;
  logic               issue;
  logic               redirect_take;
  logic               start_take;
  logic               flush;
  logic               push;
  logic               halt_hit;

  assign pop           = out_valid && out_ready;
  assign redirect_take = redirect_valid && (state_q != IDLE);
  assign start_take    = start && ((state_q == IDLE) || (state_q == HALT)) && !redirect_take;
  assign flush         = redirect_take || start_take;
  assign push          = inflight_q && !flush;
  assign halt_hit      = push && (state_q == RUN) && (mem_rdata == HALT_INSTR);
  assign next_pc_d     = (fetch_pc_q == ADDR_W'(DEPTH - 1)) ? '0 : fetch_pc_q + 1'b1;

  // Issue only if the word it produces will find a free slot: buffered + in flight,
  // less what decode takes this cycle, must leave room for one more.
  assign issue = (state_q == RUN) &&
                 (({1'b0, count} + {2'b0, inflight_q}) <= (3'd1 + {2'b0, pop}));

  assign push_entry = '{instr: mem_rdata, pc: tag_q};

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= IDLE;
      fetch_pc_q <= '0;
      tag_q      <= '0;
      inflight_q <= 1'b0;
    end else if (redirect_take) begin
      // NOTE: sequential state uses non-blocking assignments so every register
      // in this block sees the pre-edge values of the others.
      state_q    <= RUN;
      fetch_pc_q <= redirect_pc;
      inflight_q <= 1'b0;
    end else if (start_take) begin
      state_q    <= RUN;
      fetch_pc_q <= start_pc;
      inflight_q <= 1'b0;
    end else begin
      inflight_q <= issue && !halt_hit;
      if (issue) begin
        tag_q      <= fetch_pc_q;
        fetch_pc_q <= next_pc_d;
      end
      case (state_q)
        RUN:     if (halt_hit) state_q <= DRAIN;
        DRAIN:   if (count == 2'd0) state_q <= HALT;
        default: ;
      endcase
    end
  end

  fetch_skid_buf u_buf (
    .clk         (clk),
    .rst         (rst),
    .push_i      (push),
    .push_data_i (push_entry),
    .pop_i       (pop),
    .flush_i     (flush),
    .count_o     (count),
    .head_o      (head)
  );

  assign mem_addr  = fetch_pc_q;
  assign out_valid = (count != 2'd0);
  assign out_instr = head.instr;
  assign out_pc    = head.pc;
  assign halted    = (state_q == HALT);

`ifdef FETCH_PERF_EN
  logic [31:0] perf_fetched_q;
  logic [31:0] perf_stall_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      perf_fetched_q <= '0;
      perf_stall_q   <= '0;
    end else if (start_take) begin
      perf_fetched_q <= '0;
      perf_stall_q   <= '0;
    end else begin
      if (pop) perf_fetched_q <= perf_fetched_q + 32'd1;
      if (out_valid && !out_ready) perf_stall_q <= perf_stall_q + 32'd1;
    end
  end

  assign perf_fetched = perf_fetched_q;
  assign perf_stall   = perf_stall_q;
`endif

endmodule

// File: tb/tb_fetch_sequencer.sv
// Self-checking bench for fetch_sequencer: stream-level model of the delivered
// {pc, instr} sequence plus directed latency, stall, redirect, halt, wrap and reset checks.
module tb_fetch_sequencer;

  localparam int          DEPTH  = 33;
  localparam logic [31:0] HALT_W = 32'hFFFF_FFFF;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        start = 1'b0;
  logic        out_ready = 1'b0;
  logic        redirect_valid = 1'b0;
  logic [5:0]  start_pc = '0;
  logic [5:0]  redirect_pc = '0;
  logic [5:0]  mem_addr;
  logic [5:0]  out_pc;
  logic [31:0] mem_rdata = '0;
  logic [31:0] out_instr;
  logic        out_valid;
  logic        halted;
`ifdef FETCH_PERF_EN
  logic [31:0] perf_fetched;
  logic [31:0] perf_stall;
`endif

  logic [31:0] mem [DEPTH];
  int          checks = 0;
  int          errors = 0;
  int          delivered [$];
  int          exp_pc [$];
  logic [31:0] exp_instr [$];
  bit          model_idle = 1'b1;
  bit          model_halted = 1'b0;
  bit          prev_stall = 1'b0;
  logic [5:0]  prev_pc;
  logic [31:0] prev_instr;

  fetch_sequencer dut (
    .clk            (clk),
    .rst            (rst),
    .start          (start),
    .start_pc       (start_pc),
    .mem_addr       (mem_addr),
    .mem_rdata      (mem_rdata),
    .out_valid      (out_valid),
    .out_ready      (out_ready),
    .out_instr      (out_instr),
    .out_pc         (out_pc),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .halted         (halted)
`ifdef FETCH_PERF_EN
    ,
    .perf_fetched   (perf_fetched),
    .perf_stall     (perf_stall)
`endif
  );

  always #5 clk = ~clk;

  // Synchronous-read instruction memory, not affected by rst.
  always @(posedge clk) begin
    mem_rdata <= (int'(mem_addr) < DEPTH) ? mem[int'(mem_addr)] : 32'h0;
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Expected delivery stream from address p: sequential with wrap, ending at the halt word.
  function automatic void load_stream(input int p);
    int pc = p;
    exp_pc.delete();
    exp_instr.delete();
    for (int n = 0; n < 64; n++) begin
      exp_pc.push_back(pc);
      exp_instr.push_back(mem[pc]);
      if (mem[pc] == HALT_W) break;
      pc = (pc == DEPTH - 1) ? 0 : pc + 1;
    end
  endfunction

  always @(negedge clk) begin
    if (rst) begin
      exp_pc.delete();
      exp_instr.delete();
      model_idle   = 1'b1;
      model_halted = 1'b0;
      prev_stall   = 1'b0;
    end else begin
      if (prev_stall) begin
        check("stall_hold_valid", out_valid, 1);
        check("stall_hold_pc", out_pc, prev_pc);
        check("stall_hold_instr", out_instr, prev_instr);
      end
      prev_stall = out_valid && !out_ready;
      prev_pc    = out_pc;
      prev_instr = out_instr;
      if (out_valid && out_ready) begin
        delivered.push_back(int'(out_pc));
        if (exp_pc.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL extra_delivery: got pc %0d, expected no delivery", out_pc);
        end else begin
          check("deliver_pc", out_pc, exp_pc[0]);
          check("deliver_instr", out_instr, exp_instr[0]);
          if (exp_instr[0] == HALT_W) model_halted = 1'b1;
          void'(exp_pc.pop_front());
          void'(exp_instr.pop_front());
        end
      end
      if (redirect_valid && !model_idle) begin
        load_stream(int'(redirect_pc));
        model_halted = 1'b0;
        prev_stall   = 1'b0;
      end else if (start && (model_idle || model_halted)) begin
        load_stream(int'(start_pc));
        model_idle   = 1'b0;
        model_halted = 1'b0;
        prev_stall   = 1'b0;
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst            = 1'b1;
    start          = 1'b0;
    redirect_valid = 1'b0;
    out_ready      = 1'b0;
    delivered.delete();
    repeat (2) tick();
    rst = 1'b0;
  endtask

  // Returns just after the edge that samples start (edge 0).
  task automatic do_start(input logic [5:0] pc);
    start_pc = pc;
    start    = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic wait_delivered(input int n, input int budget);
    int c = 0;
    while (delivered.size() < n && c < budget) begin
      tick();
      c++;
    end
    check("wait_delivered_in_budget", (delivered.size() >= n), 1);
  endtask

  initial begin
    int n;
    int c;
    for (int i = 0; i < DEPTH; i++) mem[i] = 32'h11 + i;

    #1 rst = 1'b1;
    #1;
    check("reset_valid", out_valid, 0);
    check("reset_halted", halted, 0);
    check("reset_mem_addr", mem_addr, 0);
    check("reset_out_pc", out_pc, 0);
    check("reset_out_instr", out_instr, 0);

    // 1: start latency and back-to-back delivery
    do_reset();
    out_ready = 1'b1;
    do_start(6'd0);
    check("t1_valid_e0", out_valid, 0);
    tick();
    check("t1_valid_e1", out_valid, 0);
    tick();
    check("t1_valid_e2", out_valid, 1);
    check("t1_pc_e2", out_pc, 0);
    check("t1_instr_e2", out_instr, 32'h11);
    for (int k = 1; k <= 4; k++) begin
      tick();
      check("t1_stream_pc", out_pc, k);
      check("t1_stream_instr", out_instr, 32'h11 + k);
    end

    // 2: five-cycle stall mid-stream
    out_ready = 1'b0;
    repeat (5) tick();
    out_ready = 1'b1;
    wait_delivered(12, 40);
    for (int i = 0; i < 12; i++) check("t2_order", delivered[i], i);

    // 3: redirect with entries buffered
    do_reset();
    out_ready = 1'b1;
    do_start(6'd0);
    wait_delivered(3, 20);
    out_ready = 1'b0;
    tick();
    tick();
    n = delivered.size();
    redirect_pc    = 6'd20;
    redirect_valid = 1'b1;
    tick();
    redirect_valid = 1'b0;
    check("t3_valid_r0", out_valid, 0);
    tick();
    check("t3_valid_r1", out_valid, 0);
    tick();
    check("t3_valid_r2", out_valid, 1);
    check("t3_pc_r2", out_pc, 20);
    check("t3_instr_r2", out_instr, 32'h25);
    out_ready = 1'b1;
    wait_delivered(n + 4, 20);
    for (int j = 0; j < 4; j++) check("t3_after_redirect", delivered[n + j], 20 + j);

    // 4: halt word at address 6, then restart
    do_reset();
    mem[6]    = HALT_W;
    out_ready = 1'b1;
    do_start(6'd0);
    check("t4_halted_running", halted, 0);
    c = 0;
    while (!halted && c < 60) begin
      tick();
      c++;
    end
    check("t4_halted", halted, 1);
    check("t4_count", delivered.size(), 7);
    check("t4_last_pc", delivered[delivered.size() - 1], 6);
    repeat (5) tick();
    check("t4_no_pc7", delivered.size(), 7);
    check("t4_still_halted", halted, 1);
    do_start(6'd0);
    check("t4_restart_halted", halted, 0);
    tick();
    tick();
    check("t4_restart_valid", out_valid, 1);
    check("t4_restart_pc", out_pc, 0);
    wait_delivered(14, 40);

    // 5: wrap-around from DEPTH-2
    do_reset();
    mem[6]    = 32'h17;
    out_ready = 1'b1;
    do_start(6'd31);
    wait_delivered(4, 20);
    check("t5_pc0", delivered[0], 31);
    check("t5_pc1", delivered[1], 32);
    check("t5_pc2", delivered[2], 0);
    check("t5_pc3", delivered[3], 1);

    // 6: asynchronous reset mid-run
    @(posedge clk);
    #2;
    check("t6_pre_valid", out_valid, 1);
    #1 rst = 1'b1;
    #1;
    check("t6_valid", out_valid, 0);
    check("t6_halted", halted, 0);
    check("t6_mem_addr", mem_addr, 0);
    repeat (2) tick();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1);
  end

endmodule
